// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction FSM, DP/MEM/B decode, NZCV flag register, condition check.
// Latency: FETCH + DECODE, then 1-3 further states per instruction; outputs are combinational from state/Instr.
// Backpressure: MemReady low stalls FETCH/MEMRD/MEMWR; WAIT_LIMIT+1 stalled cycles -> sticky MemTimeout, back to FETCH.
// Optional feature: define MCCTRL_MUL_EN to decode MUL (requires ALUCTRL_W >= 3).
module multicycle_controller #(
    parameter int ALUCTRL_W  = 3,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           RegSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 MemTimeout
);

    localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);

    if (ALUCTRL_W < 2) begin : g_alu_width_check
        $error("ALUCTRL_W must be at least 2");
    end

`ifdef MCCTRL_MUL_EN
    localparam logic [ALUCTRL_W-1:0] ALU_MUL = ALUCTRL_W'(4);

    if (ALUCTRL_W < 3) begin : g_mul_width_check
        $error("ALUCTRL_W must be at least 3 when MUL decode is enabled");
    end
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       s_bit;
    logic       cond_ex;
    logic       mem_state;
    logic       timeout;

    // decoded data-processing attributes
    logic [ALUCTRL_W-1:0] alu_op;
    logic                 dp_wb;   // result is written back
    logic                 dp_fw;   // S bit may update flags
    logic                 dp_cv;   // S bit also updates C and V
    logic [3:0]           rd_sel;  // destination register of the writeback

    // unregistered enables before the reset gate
    logic pc_we, mem_we, reg_we, ir_we;

    logic unused_bits;
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};

    assign op     = Instr[27:26];
    assign cmd    = Instr[24:21];
    assign s_bit  = Instr[20];
    assign ImmSrc = Instr[27:26];
    assign RegSrc = {op == 2'b01, op == 2'b10};

    // Funct decode into ALU operation and writeback/flag attributes
    always_comb begin
        alu_op = ALU_ADD;
        dp_wb  = 1'b0;
        dp_fw  = 1'b0;
        dp_cv  = 1'b0;
        rd_sel = Instr[15:12];
        case (cmd)
            4'b0100: begin alu_op = ALU_ADD; dp_wb = 1'b1; dp_fw = 1'b1; dp_cv = 1'b1; end
            4'b0010: begin alu_op = ALU_SUB; dp_wb = 1'b1; dp_fw = 1'b1; dp_cv = 1'b1; end
            4'b0000: begin alu_op = ALU_AND; dp_wb = 1'b1; dp_fw = 1'b1; end
            4'b1100: begin alu_op = ALU_ORR; dp_wb = 1'b1; dp_fw = 1'b1; end
            4'b1010: begin alu_op = ALU_SUB; dp_fw = 1'b1; dp_cv = 1'b1; end
            default: ;
        endcase
`ifdef MCCTRL_MUL_EN
        // MUL shares the AND encoding space; Rd lives in [19:16]
        if (op == 2'b00 && Instr[25:24] == 2'b00 && Instr[7:4] == 4'b1001) begin
            alu_op = ALU_MUL;
            dp_wb  = 1'b1;
            dp_fw  = 1'b1;
            dp_cv  = 1'b0;
            rd_sel = Instr[19:16];
        end
`endif
    end

    // ARM condition field evaluated against the stored NZCV
    always_comb begin
        cond_ex = 1'b0;
        case (Instr[31:28])
            4'h0: cond_ex = flags_q[2];
            4'h1: cond_ex = ~flags_q[2];
            4'h2: cond_ex = flags_q[1];
            4'h3: cond_ex = ~flags_q[1];
            4'h4: cond_ex = flags_q[3];
            4'h5: cond_ex = ~flags_q[3];
            4'h6: cond_ex = flags_q[0];
            4'h7: cond_ex = ~flags_q[0];
            4'h8: cond_ex = flags_q[1] & ~flags_q[2];
            4'h9: cond_ex = ~flags_q[1] | flags_q[2];
            4'hA: cond_ex = (flags_q[3] == flags_q[0]);
            4'hB: cond_ex = (flags_q[3] != flags_q[0]);
            4'hC: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'hD: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // S-bit flag capture during execute; logic ops and MUL leave C/V alone
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && s_bit && cond_ex && dp_fw) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (dp_cv) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = mem_state && !MemReady && (cnt_q == CNT_W'(WAIT_LIMIT));

    // Stall counter: any completed access or state change starts it over
    always_comb begin
        cnt_d = '0;
        if (mem_state && !MemReady && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        to_d = to_q | timeout;
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        ir_we      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_we     = MemReady;
                pc_we     = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_d = Instr[25] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = cond_ex;
                pc_we     = cond_ex && (Instr[15:12] == 4'hF);
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_we = cond_ex & MemReady;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUControl = alu_op;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = cond_ex & dp_wb;
                pc_we   = cond_ex && dp_wb && (rd_sel == 4'hF);
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = cond_ex;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // hung memory: abandon the instruction without side effects
        if (timeout) begin
            state_d = S_FETCH;
            pc_we   = 1'b0;
            mem_we  = 1'b0;
            reg_we  = 1'b0;
            ir_we   = 1'b0;
        end
    end

    // Write enables are held off for the whole time reset is low
    assign PCWrite    = pc_we  & reset;
    assign MemWrite   = mem_we & reset;
    assign RegWrite   = reg_we & reset;
    assign IRWrite    = ir_we  & reset;
    assign MemTimeout = to_q;

    // State, flags, stall counter and sticky timeout registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-level bench for multicycle_controller against a phase-sequence reference model.
// Each instruction is expanded into its expected cycle sequence; every cycle compares all outputs.
// Memory stalls, timeouts, the 15/16 stall boundary and reset during a store are included.
module tb_multicycle_controller;

    localparam int AW         = 3;
    localparam int WAIT_LIMIT = 15;

    logic          clk;
    logic          rst_n;
    logic [31:0]   Instr;
    logic [3:0]    ALUFlags;
    logic          MemReady;
    logic          PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, MemTimeout;
    logic [1:0]    RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [AW-1:0] ALUControl;

    multicycle_controller #(.ALUCTRL_W(AW), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .reset(rst_n), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .MemTimeout(MemTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB,
                  P_MEMWR, P_EXECR, P_EXECI, P_ALUWB, P_BRANCH} phase_e;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] m_ins;
    logic [3:0]  m_af;
    logic [3:0]  m_flags;
    logic        m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (instr %h)", tag, got, want, m_ins);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return 32'({PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ImmSrc, ALUControl, MemTimeout});
    endfunction

    // ARM conditions as (base predicate, inverted by cond[0]); 1110 always, 1111 never
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return c[0] ? !base : base;
    endfunction

    // command table: opcode, ALU code, writes Rd, updates C/V
    function automatic void dp_decode(input logic [31:0] ins, output logic [2:0] alu,
                                      output logic wb, output logic fw, output logic cv,
                                      output logic [3:0] rd);
        logic [3:0] tab_cmd [5];
        logic [2:0] tab_alu [5];
        bit         tab_wb  [5];
        bit         tab_cv  [5];
        tab_cmd = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        tab_alu = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1};
        tab_wb  = '{1, 1, 1, 1, 0};
        tab_cv  = '{1, 1, 0, 0, 1};
        alu = 3'd0; wb = 1'b0; fw = 1'b0; cv = 1'b0; rd = ins[15:12];
        for (int i = 0; i < 5; i++) begin
            if (ins[24:21] == tab_cmd[i]) begin
                alu = tab_alu[i]; wb = tab_wb[i]; fw = 1'b1; cv = tab_cv[i];
            end
        end
`ifdef MCCTRL_MUL_EN
        if (ins[27:24] == 4'b0000 && ins[7:4] == 4'b1001) begin
            alu = 3'd4; wb = 1'b1; fw = 1'b1; cv = 1'b0; rd = ins[19:16];
        end
`endif
    endfunction

    function automatic logic [31:0] expect_outs(input phase_e ph, input logic mr);
        logic       pcw, mw, rw, irw, adr, asa, ce, wb, fw, cv;
        logic [1:0] asb, res;
        logic [2:0] alu, aluc;
        logic [3:0] rd;
        {pcw, mw, rw, irw, adr, asa} = 6'b0;
        asb = 2'b00; res = 2'b00; aluc = 3'd0;
        ce = cond_holds(m_ins[31:28], m_flags);
        dp_decode(m_ins, alu, wb, fw, cv, rd);
        case (ph)
            P_RESET:  begin asa = 1; asb = 2'b10; res = 2'b10; end
            P_FETCH:  begin asa = 1; asb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            P_DECODE: begin asa = 1; asb = 2'b10; res = 2'b10; end
            P_MEMADR: asb = 2'b01;
            P_MEMRD:  adr = 1;
            P_MEMWB:  begin res = 2'b01; rw = ce; pcw = ce && (m_ins[15:12] == 4'hF); end
            P_MEMWR:  begin adr = 1; mw = ce && mr; end
            P_EXECR:  aluc = alu;
            P_EXECI:  begin asb = 2'b01; aluc = alu; end
            P_ALUWB:  begin rw = ce && wb; pcw = ce && wb && (rd == 4'hF); end
            P_BRANCH: begin asb = 2'b01; res = 2'b10; pcw = ce; end
            default: ;
        endcase
        return 32'({pcw, mw, rw, irw, adr, (m_ins[27:26] == 2'b01), (m_ins[27:26] == 2'b10),
                    asa, asb, res, m_ins[27:26], aluc, m_to});
    endfunction

    // one clock: drive at the falling edge, compare 1 time unit later
    task automatic cyc(input string tag, input logic mr, input logic [31:0] want);
        @(negedge clk);
        Instr    = m_ins;
        ALUFlags = m_af;
        MemReady = mr;
        #1;
        check(tag, dut_outs(), want);
    endtask

    // stalled memory phase: 'low' not-ready cycles, then completion unless it times out
    task automatic mem_wait(input phase_e ph, input string tag, input int low, output bit aborted);
        aborted = 1'b0;
        for (int k = 0; k < low && k <= WAIT_LIMIT; k++) begin
            cyc(tag, 1'b0, expect_outs(ph, 1'b0));
            if (k == WAIT_LIMIT) begin
                m_to    = 1'b1;
                aborted = 1'b1;
                return;
            end
        end
        cyc(tag, 1'b1, expect_outs(ph, 1'b1));
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fl, input int ml, input logic [3:0] af);
        bit         ab;
        logic [2:0] alu;
        logic       wb, fw, cv;
        logic [3:0] rd;
        m_ins = ins;
        m_af  = af;
        mem_wait(P_FETCH, "fetch", fl, ab);
        if (ab) return;
        cyc("decode", 1'($urandom), expect_outs(P_DECODE, 1'b0));
        case (ins[27:26])
            2'b01: begin
                cyc("memadr", 1'($urandom), expect_outs(P_MEMADR, 1'b0));
                if (ins[20]) begin
                    mem_wait(P_MEMRD, "memrd", ml, ab);
                    if (!ab) cyc("memwb", 1'($urandom), expect_outs(P_MEMWB, 1'b0));
                end else begin
                    mem_wait(P_MEMWR, "memwr", ml, ab);
                end
            end
            2'b00: begin
                cyc(ins[25] ? "execi" : "execr", 1'($urandom),
                    expect_outs(ins[25] ? P_EXECI : P_EXECR, 1'b0));
                dp_decode(ins, alu, wb, fw, cv, rd);
                if (ins[20] && fw && cond_holds(ins[31:28], m_flags)) begin
                    m_flags[3:2] = af[3:2];
                    if (cv) m_flags[1:0] = af[1:0];
                end
                cyc("aluwb", 1'($urandom), expect_outs(P_ALUWB, 1'b0));
            end
            2'b10: cyc("branch", 1'($urandom), expect_outs(P_BRANCH, 1'b0));
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [3:0]  cmds [5];
        int          r;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        w = $urandom;
        r = $urandom_range(0, 19);
        if (r < 8)       w[31:28] = 4'hE;
        else if (r == 8) w[31:28] = 4'hF;
        else             w[31:28] = 4'($urandom_range(0, 13));
        if (w[27:26] == 2'b00 && $urandom_range(0, 3) != 0) w[24:21] = cmds[$urandom_range(0, 4)];
        if ($urandom_range(0, 7) == 0) w[15:12] = 4'hF;
        if ($urandom_range(0, 9) == 0) begin
            w[27:24] = 4'b0000;
            w[7:4]   = 4'b1001;
        end
        return w;
    endfunction

    function automatic int rand_low();
        int r;
        r = $urandom_range(0, 39);
        if (r <= 33) return r % 4;
        if (r <= 36) return WAIT_LIMIT;
        if (r <= 38) return WAIT_LIMIT + 1;
        return 2;
    endfunction

    task automatic do_reset_release();
        @(negedge clk);
        rst_n    = 1'b1;
        MemReady = 1'b0;
    endtask

    initial begin
        bit ab;
        rst_n    = 1'b0;
        Instr    = 32'hE2821005;
        ALUFlags = 4'h0;
        MemReady = 1'b1;
        m_ins = 32'hE2821005; m_af = 4'h0; m_flags = 4'h0; m_to = 1'b0;

        // reset: FETCH selects, every write enable low even with MemReady high
        @(negedge clk); #1;
        check("reset_a", dut_outs(), expect_outs(P_RESET, 1'b1));
        @(negedge clk); #1;
        check("reset_b", dut_outs(), expect_outs(P_RESET, 1'b1));
        do_reset_release();

        // ADD R1,R2,#5: F/D/EXECI/ALUWB with RegWrite in ALUWB
        run_instr(32'hE2821005, 0, 0, 4'h0);
        // SUBS R0,R0,R0 with Z from the ALU, then BEQ taken, BNE not taken
        run_instr(32'hE0500000, 0, 0, 4'b0100);
        run_instr(32'h0A000002, 0, 0, 4'h0);
        run_instr(32'h1A000002, 0, 0, 4'h0);
        // LDR with three stalled cycles in MEMRD
        run_instr(32'hE5921004, 0, 3, 4'h0);
        // STR with a stall, then stall boundary: 15 low still completes, 16 low times out
        run_instr(32'hE5821004, 1, 2, 4'h0);
        run_instr(32'hE2821005, WAIT_LIMIT, 0, 4'h0);
        run_instr(32'hE2821005, WAIT_LIMIT + 1, 0, 4'h0);
        run_instr(32'hE2821005, 0, 0, 4'h0);
`ifdef MCCTRL_MUL_EN
        run_instr(32'hE0030291, 0, 0, 4'h0);
`endif

        for (int i = 0; i < 250; i++) begin
            run_instr(rand_instr(), rand_low(), rand_low(), 4'($urandom));
        end

        // set Z and force the sticky timeout, then reset in the middle of a store
        run_instr(32'hE0500000, 0, 0, 4'b0100);
        run_instr(32'hE5821004, WAIT_LIMIT + 1, 0, 4'h0);
        m_ins = 32'hE5821004;
        m_af  = 4'h0;
        mem_wait(P_FETCH, "rst_fetch", 0, ab);
        cyc("rst_decode", 1'b1, expect_outs(P_DECODE, 1'b0));
        cyc("rst_memadr", 1'b1, expect_outs(P_MEMADR, 1'b0));
        cyc("rst_memwr_pre", 1'b1, expect_outs(P_MEMWR, 1'b1));
        rst_n = 1'b0;
        #1;
        m_flags = 4'h0;
        m_to    = 1'b0;
        check("rst_memwr_during", dut_outs(), expect_outs(P_RESET, 1'b1));
        do_reset_release();
        // flags cleared: BEQ not taken, BNE taken, no timeout
        run_instr(32'h0A000002, 0, 0, 4'h0);
        run_instr(32'h1A000002, 0, 0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
